// File: rtl/out_word_uart_tx.sv
// Word-buffered UART transmitter: each 32-bit word leaves as four bytes, byte 0 = bits [7:0] first.
// Optional even-parity bit per byte when OUT_WORD_UART_TX_PARITY_EN is defined (8E1, else 8N1).
module out_word_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic        full,
    output logic        busy,
    output logic        overflow,
    output logic        tx
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned TMR_W  = 16;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned BYTE_W = 2;

    localparam logic [TMR_W-1:0]  BIT_RELOAD = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(7);
    localparam logic [BYTE_W-1:0] LAST_BYTE  = BYTE_W'(3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
`ifdef OUT_WORD_UART_TX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_busy;
    logic              r_overflow;
    logic              r_tx;

    state_t             r_state;
    logic [TMR_W-1:0]   r_timer;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [BYTE_W-1:0]  r_byte_cnt;
    logic [WORD_W-1:0]  r_shift;

    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_count_next;
    state_t             w_state_next;
    logic [TMR_W-1:0]   w_timer_next;
    logic [BIT_W-1:0]   w_bit_next;
    logic [BYTE_W-1:0]  w_byte_next;
    logic [WORD_W-1:0]  w_shift_next;
    logic               w_bit_end;
    logic               w_tx_next;

`ifdef OUT_WORD_UART_TX_PARITY_EN
    logic               r_parity;
    logic               w_parity_next;
`endif

    assign full     = r_full;
    assign busy     = r_busy;
    assign overflow = r_overflow;
    assign tx       = r_tx;

    // Writes are judged against the registered full flag; the only pop is in LOAD.
    assign w_push    = wr_en & ~r_full;
    assign w_pop     = (r_state == S_LOAD);
    assign w_bit_end = (r_timer == '0);

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // FIFO payload storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count    <= w_count_next;
            r_full     <= (w_count_next == CNT_FULL);
            r_overflow <= r_overflow | (wr_en & r_full);
        end
    end

    // Serializer next-state: every bit lasts CLKS_PER_BIT cycles, boundary when the timer hits 0.
    always_comb begin
        w_state_next  = r_state;
        w_timer_next  = r_timer;
        w_bit_next    = r_bit_cnt;
        w_byte_next   = r_byte_cnt;
        w_shift_next  = r_shift;
`ifdef OUT_WORD_UART_TX_PARITY_EN
        w_parity_next = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_shift_next = r_mem[r_rd_ptr];
                w_byte_next  = '0;
                w_bit_next   = '0;
                w_timer_next = BIT_RELOAD;
                w_state_next = S_START;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next  = S_DATA;
                    w_timer_next  = BIT_RELOAD;
                    w_bit_next    = '0;
`ifdef OUT_WORD_UART_TX_PARITY_EN
                    w_parity_next = 1'b0;
`endif
                end else begin
                    w_timer_next = r_timer - TMR_W'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_next  = {1'b0, r_shift[WORD_W-1:1]};
                    w_timer_next  = BIT_RELOAD;
`ifdef OUT_WORD_UART_TX_PARITY_EN
                    w_parity_next = r_parity ^ r_shift[0];
`endif
                    if (r_bit_cnt == LAST_BIT) begin
`ifdef OUT_WORD_UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_bit_next = r_bit_cnt + BIT_W'(1);
                    end
                end else begin
                    w_timer_next = r_timer - TMR_W'(1);
                end
            end
`ifdef OUT_WORD_UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                    w_timer_next = BIT_RELOAD;
                end else begin
                    w_timer_next = r_timer - TMR_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_byte_cnt != LAST_BYTE) begin
                        w_byte_next  = r_byte_cnt + BYTE_W'(1);
                        w_timer_next = BIT_RELOAD;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_timer_next = r_timer - TMR_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Line level for the coming cycle, derived from where the serializer is heading.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
`ifdef OUT_WORD_UART_TX_PARITY_EN
            S_PARITY: w_tx_next = w_parity_next;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
`ifdef OUT_WORD_UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_timer    <= w_timer_next;
            r_bit_cnt  <= w_bit_next;
            r_byte_cnt <= w_byte_next;
            r_shift    <= w_shift_next;
            r_tx       <= w_tx_next;
            r_busy     <= (w_count_next != '0) || (w_state_next != S_IDLE);
`ifdef OUT_WORD_UART_TX_PARITY_EN
            r_parity   <= w_parity_next;
`endif
        end
    end

endmodule

// File: tb/tb_out_word_uart_tx.sv
// Bench for out_word_uart_tx: queue/waveform reference model compared every cycle, plus literal pins.
module tb_out_word_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        wr_en   = 1'b0;
    logic [31:0] wr_data = 32'h0;
    logic        full, busy, overflow, tx;

    out_word_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .busy(busy), .overflow(overflow), .tx(tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: word queue plus a queue of expected per-cycle line samples
    // (0/1 = frame level, 2 = the idle-return cycle that ends every word).
    logic [31:0] mq[$];
    int          txq[$];
    int          m_sz;
    int          m_s;
    bit          m_load  = 1'b0;
    bit          m_frame = 1'b0;
    bit          m_ovf   = 1'b0;
    bit          m_tx    = 1'b1;
    bit          m_busy  = 1'b0;
    bit          m_full  = 1'b0;

    task automatic push_bit(input int v);
        for (int c = 0; c < CPB; c++) txq.push_back(v);
    endtask

    task automatic push_frame(input logic [31:0] w);
        logic [7:0] d;
        for (int b = 0; b < 4; b++) begin
            d = w[8*b +: 8];
            push_bit(0);
            for (int i = 0; i < 8; i++) push_bit(int'(d[i]));
`ifdef OUT_WORD_UART_TX_PARITY_EN
            push_bit(int'(^d));
`endif
            push_bit(1);
        end
        txq.push_back(2);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            txq.delete();
            m_load = 1'b0; m_frame = 1'b0; m_ovf = 1'b0;
            m_tx = 1'b1; m_busy = 1'b0; m_full = 1'b0;
        end else begin
            m_sz = mq.size();
            if (wr_en && m_sz == DEPTH) m_ovf = 1'b1;
            if (m_load) begin
                push_frame(mq.pop_front());
                m_load = 1'b0;
            end else if (txq.size() == 0 && m_sz > 0) begin
                m_load = 1'b1;
            end
            if (wr_en && m_sz < DEPTH) mq.push_back(wr_data);
            if (txq.size() > 0) begin
                m_s = txq.pop_front();
                m_tx = (m_s != 0);
                m_frame = (m_s != 2);
            end else begin
                m_tx = 1'b1;
                m_frame = 1'b0;
            end
            m_full = (mq.size() == DEPTH);
            m_busy = (mq.size() > 0) || m_load || m_frame;
        end
    end

    // Literal expectations keyed by absolute edge number.
    logic pin_tx   [int];
    logic pin_busy [int];
    logic pin_full [int];
    logic pin_ovf  [int];
    logic rst_chk   = 1'b0;
    logic drain_chk = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %b expected %b", nm, cyc, act, exp);
    endtask

    always @(negedge clk or posedge rst_chk) begin
        if (rst_chk) begin
            check("rst_tx", tx, 1'b1);
            check("rst_busy", busy, 1'b0);
            check("rst_full", full, 1'b0);
            check("rst_overflow", overflow, 1'b0);
        end else if (reset) begin
            check("tx", tx, m_tx);
            check("busy", busy, m_busy);
            check("full", full, m_full);
            check("overflow", overflow, m_ovf);
            if (pin_tx.exists(cyc))   check("pin_tx", tx, pin_tx[cyc]);
            if (pin_busy.exists(cyc)) check("pin_busy", busy, pin_busy[cyc]);
            if (pin_full.exists(cyc)) check("pin_full", full, pin_full[cyc]);
            if (pin_ovf.exists(cyc))  check("pin_overflow", overflow, pin_ovf[cyc]);
            if (drain_chk)            check("drain_idle", busy, 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_edge(input int e);
        while (cyc < e) tick();
    endtask

    task automatic write_word(input logic [31:0] w, output int e);
        wr_en = 1'b1;
        wr_data = w;
        tick();
        e = cyc;
        wr_en = 1'b0;
    endtask

    task automatic burst(input int n, output int e);
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1;
            wr_data = $urandom();
            tick();
            if (i == 0) e = cyc;
        end
        wr_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 4000; i++) begin
            if (!busy) break;
            tick();
        end
        repeat (3) tick();
        drain_chk = 1'b1;
        @(negedge clk);
        #1;
        drain_chk = 1'b0;
        tick();
    endtask

    task automatic apply_reset();
        #1 reset = 1'b0;
        #1 rst_chk = 1'b1;
        #1 rst_chk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    int k;
    int k2;
    logic [31:0] wc;

    initial begin
        #2 reset = 1'b0;
        #1 rst_chk = 1'b1;
        #1 rst_chk = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;

`ifndef OUT_WORD_UART_TX_PARITY_EN
        // Single word, written on the first edge after reset release.
        write_word(32'hA5C30F01, k);
        pin_tx[k+1] = 1'b1;  pin_tx[k+2] = 1'b0;
        pin_tx[k+6] = 1'b1;  pin_tx[k+10] = 1'b0;
        pin_tx[k+38] = 1'b1; pin_tx[k+42] = 1'b0; pin_tx[k+46] = 1'b1;
        pin_tx[k+150] = 1'b0; pin_tx[k+154] = 1'b1;
        pin_busy[k+161] = 1'b1; pin_busy[k+162] = 1'b0;
        drain();
`else
        write_word(32'h00000007, k);
        pin_tx[k+2] = 1'b0;  pin_tx[k+38] = 1'b1; pin_tx[k+42] = 1'b1;
        pin_tx[k+46] = 1'b0; pin_tx[k+82] = 1'b0;
        pin_busy[k+177] = 1'b1; pin_busy[k+178] = 1'b0;
        drain();
`endif

        // Five writes while idle: one pop precedes the fifth, nothing dropped.
        burst(5, k);
        pin_full[k+3] = 1'b0; pin_full[k+4] = 1'b1; pin_ovf[k+4] = 1'b0;
        drain();

        // Five writes while serializer is mid-word: fifth is dropped.
        write_word($urandom(), k2);
        wait_edge(k2 + 10);
        burst(5, k);
        pin_full[k+3] = 1'b1; pin_ovf[k+3] = 1'b0; pin_ovf[k+4] = 1'b1;
        drain();

        // Reset during byte 2 of a word with another word still buffered.
        write_word($urandom(), k);
        write_word($urandom(), k2);
        wait_edge(k + 100);
        apply_reset();
        wc = $urandom();
        write_word(wc, k2);
        pin_tx[k2+2] = 1'b0; pin_tx[k2+6] = wc[0]; pin_tx[k2+10] = wc[1];
        drain();

        // Fill to full, then a write that must be dropped.
        burst(5, k);
        write_word(32'hDEADBEEF, k2);
        pin_full[k+4] = 1'b1; pin_ovf[k+4] = 1'b0;
        pin_full[k+5] = 1'b1; pin_ovf[k+5] = 1'b1;
        drain();

        // Random traffic.
        for (int i = 0; i < 700; i++) begin
            wr_en = ($urandom_range(0, 15) < 2);
            wr_data = $urandom();
            tick();
        end
        wr_en = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
